// File: rtl/ifu_fetch.sv
// Instruction fetch stage: holds the architectural PC, issues one AXI-lite
// style read per instruction and hands the fetched word to decode through a
// valid/ready handshake. Redirects are accepted in any state; responses that
// belong to a wrong-path fetch are dropped rather than presented.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | one cycle after reset, no request yet
// REQ   | o_araddr = pc offered to memory, waiting for i_arready
// WAIT  | address accepted, waiting for the read response
// HOLD  | fetched word presented to decode, waiting for i_ready/redirect
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic [31:0] o_araddr,
  output logic        o_arvalid,
  input  logic        i_arready,
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_rresp,
  input  logic        i_rvalid,
  output logic        o_rready,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic        o_ins_err,
  output logic        o_valid,
  input  logic        i_ready
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pend_pc;
  logic        pend;
  logic        kill;
  logic [31:0] redir_tgt;

  // Instructions are word aligned, so the low two target bits are discarded.
  assign redir_tgt = {i_redirect_pc[31:2], 2'b00};

  // Fetch sequencing, PC update, redirect bookkeeping and output holding regs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      pend_pc   <= RESET_PC;
      pend      <= 1'b0;
      kill      <= 1'b0;
      o_instr   <= 32'h0;
      o_pc      <= RESET_PC;
      o_ins_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          // Nothing is in flight yet, so a redirect can retarget directly.
          if (i_redirect) pc <= redir_tgt;
          state <= S_REQ;
        end
        S_REQ: begin
          // The offered address cannot be withdrawn; remember the target and
          // discard the response once it comes back.
          if (i_redirect) begin
            pend    <= 1'b1;
            kill    <= 1'b1;
            pend_pc <= redir_tgt;
          end
          if (i_arready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (i_rvalid) begin
            // A redirect arriving together with the response makes that
            // response wrong-path as well; the newest target wins.
            if (kill || pend || i_redirect) begin
              pc    <= i_redirect ? redir_tgt : pend_pc;
              pend  <= 1'b0;
              kill  <= 1'b0;
              state <= S_REQ;
            end else begin
              o_instr   <= i_rdata;
              o_pc      <= pc;
              o_ins_err <= (i_rresp != 2'b00);
              state     <= S_HOLD;
            end
          end else if (i_redirect) begin
            pend    <= 1'b1;
            kill    <= 1'b1;
            pend_pc <= redir_tgt;
          end
        end
        S_HOLD: begin
          // Redirect takes priority over a simultaneous consume.
          if (i_redirect) begin
            pc    <= redir_tgt;
            state <= S_REQ;
          end else if (i_ready) begin
            pc    <= pc + 32'd4;
            state <= S_REQ;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_araddr  = pc;
  assign o_arvalid = (state == S_REQ);
  assign o_rready  = (state == S_WAIT);
  assign o_valid   = (state == S_HOLD) && !kill;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a small instruction-memory responder.
// Memory returns ~address as the instruction word, and a fault (resp 2'b10,
// data 32'h13) for the one address held in fault_addr.
module tb_ifu_fetch;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic [31:0] o_araddr;
  logic        o_arvalid;
  logic        i_arready = 1'b1;
  logic [31:0] i_rdata = 32'h0;
  logic [1:0]  i_rresp = 2'b00;
  logic        i_rvalid = 1'b0;
  logic        o_rready;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        o_ins_err;
  logic        o_valid;
  logic        i_ready = 1'b1;

  int checks = 0;
  int errors = 0;

  int          lat = 0;
  logic [31:0] fault_addr = 32'h0000_0001;

  ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_araddr(o_araddr), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_instr(o_instr), .o_pc(o_pc), .o_ins_err(o_ins_err), .o_valid(o_valid),
    .i_ready(i_ready)
  );

  always #5 i_clk = ~i_clk;

  // Memory responder: samples handshakes at the edge, updates drives 1ns later.
  logic        m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;
  always @(posedge i_clk) begin
    logic        ar_hs;
    logic        r_hs;
    logic [31:0] a;
    ar_hs = o_arvalid && i_arready;
    r_hs  = i_rvalid && o_rready;
    a     = o_araddr;
    #1;
    if (i_rst) begin
      m_busy   = 1'b0;
      m_cnt    = 0;
      i_rvalid = 1'b0;
    end else begin
      if (r_hs) begin
        i_rvalid = 1'b0;
        m_busy   = 1'b0;
      end
      if (ar_hs) begin
        m_busy = 1'b1;
        m_cnt  = lat;
        m_addr = a;
      end
      if (m_busy && !i_rvalid) begin
        if (m_cnt == 0) begin
          i_rvalid = 1'b1;
          if (m_addr == fault_addr) begin
            i_rdata = 32'h0000_0013;
            i_rresp = 2'b10;
          end else begin
            i_rdata = ~m_addr;
            i_rresp = 2'b00;
          end
        end else begin
          m_cnt = m_cnt - 1;
        end
      end
    end
  end

  // Reset DUT and memory together; returns at the negedge where reset drops.
  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_redirect = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic wait_valid(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge i_clk);
      if (o_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ar(input int max, output bit ok, output int nval);
    ok = 1'b0;
    nval = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge i_clk);
      if (o_valid) nval++;
      if (o_arvalid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    lat = 0; i_arready = 1'b1; i_ready = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b want 0", o_arvalid); end
    checks++; if (o_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %b want 0", o_rready); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", o_valid); end
    checks++; if (o_pc !== 32'h8000_0000) begin errors++; $display("FAIL rst_pc got %h want 80000000", o_pc); end
    checks++; if (o_instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h want 0", o_instr); end
    checks++; if (o_ins_err !== 1'b0) begin errors++; $display("FAIL rst_ins_err got %b want 0", o_ins_err); end
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0000) begin errors++; $display("FAIL first_req got v=%b a=%h want 1 80000000", o_arvalid, o_araddr); end
    @(negedge i_clk);
    checks++; if (o_rready !== 1'b1 || o_arvalid !== 1'b0 || o_valid !== 1'b0) begin errors++; $display("FAIL first_wait got rr=%b av=%b v=%b want 1 0 0", o_rready, o_arvalid, o_valid); end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0000 || o_instr !== 32'h7FFF_FFFF || o_ins_err !== 1'b0)
      begin errors++; $display("FAIL first_out got v=%b pc=%h i=%h e=%b want 1 80000000 7fffffff 0", o_valid, o_pc, o_instr, o_ins_err); end
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0004) begin errors++; $display("FAIL second_req got v=%b a=%h want 1 80000004", o_arvalid, o_araddr); end
    repeat (2) @(negedge i_clk);
    checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0004 || o_instr !== 32'h7FFF_FFFB)
      begin errors++; $display("FAIL second_out got v=%b pc=%h i=%h want 1 80000004 7ffffffb", o_valid, o_pc, o_instr); end
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0008) begin errors++; $display("FAIL third_req got v=%b a=%h want 1 80000008", o_arvalid, o_araddr); end
  endtask

  task automatic test_stall();
    bit ok;
    lat = 0; i_arready = 1'b1; i_ready = 1'b0;
    do_reset();
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_timeout got no o_valid want o_valid within 10 cycles"); end
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checks++; if (o_valid !== 1'b1 || o_pc !== 32'h8000_0000 || o_instr !== 32'h7FFF_FFFF || o_arvalid !== 1'b0)
        begin errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h i=%h av=%b want 1 80000000 7fffffff 0", i, o_valid, o_pc, o_instr, o_arvalid); end
    end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0004 || o_valid !== 1'b0)
      begin errors++; $display("FAIL stall_release got av=%b a=%h v=%b want 1 80000004 0", o_arvalid, o_araddr, o_valid); end
  endtask

  task automatic test_redirect_wait();
    bit ok;
    int nv;
    lat = 3; i_arready = 1'b1; i_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge i_clk);
    checks++; if (o_rready !== 1'b1) begin errors++; $display("FAIL rw_in_wait got rr=%b want 1", o_rready); end
    i_redirect = 1'b1; i_redirect_pc = 32'h8000_0101;
    @(negedge i_clk);
    i_redirect = 1'b0;
    wait_ar(15, ok, nv);
    checks++; if (!ok || nv != 0 || o_araddr !== 32'h8000_0100)
      begin errors++; $display("FAIL rw_refetch got ok=%b nvalid=%0d a=%h want 1 0 80000100", ok, nv, o_araddr); end
    wait_valid(15, ok);
    checks++; if (!ok || o_pc !== 32'h8000_0100 || o_instr !== 32'h7FFF_FEFF)
      begin errors++; $display("FAIL rw_out got ok=%b pc=%h i=%h want 1 80000100 7ffffeff", ok, o_pc, o_instr); end
    lat = 0;
  endtask

  task automatic test_redirect_req();
    bit ok;
    int nv;
    lat = 0; i_arready = 1'b0; i_ready = 1'b1;
    do_reset();
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0000) begin errors++; $display("FAIL rq_req got av=%b a=%h want 1 80000000", o_arvalid, o_araddr); end
    i_redirect = 1'b1; i_redirect_pc = 32'h8000_0200;
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0000) begin errors++; $display("FAIL rq_stable1 got av=%b a=%h want 1 80000000", o_arvalid, o_araddr); end
    i_redirect_pc = 32'h8000_0300;
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0000) begin errors++; $display("FAIL rq_stable2 got av=%b a=%h want 1 80000000", o_arvalid, o_araddr); end
    i_redirect = 1'b0; i_arready = 1'b1;
    wait_ar(15, ok, nv);
    checks++; if (!ok || nv != 0 || o_araddr !== 32'h8000_0300)
      begin errors++; $display("FAIL rq_refetch got ok=%b nvalid=%0d a=%h want 1 0 80000300", ok, nv, o_araddr); end
    wait_valid(15, ok);
    checks++; if (!ok || o_pc !== 32'h8000_0300 || o_instr !== 32'h7FFF_FCFF)
      begin errors++; $display("FAIL rq_out got ok=%b pc=%h i=%h want 1 80000300 7ffffcff", ok, o_pc, o_instr); end
  endtask

  task automatic test_redirect_ready();
    bit ok;
    lat = 0; i_arready = 1'b1; i_ready = 1'b1;
    do_reset();
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rr_timeout got no o_valid want o_valid within 10 cycles"); end
    i_redirect = 1'b1; i_redirect_pc = 32'h8000_0040;
    @(negedge i_clk);
    i_redirect = 1'b0;
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000_0040 || o_valid !== 1'b0)
      begin errors++; $display("FAIL rr_target got av=%b a=%h v=%b want 1 80000040 0", o_arvalid, o_araddr, o_valid); end
    wait_valid(10, ok);
    checks++; if (!ok || o_pc !== 32'h8000_0040) begin errors++; $display("FAIL rr_out got ok=%b pc=%h want 1 80000040", ok, o_pc); end
  endtask

  task automatic test_fault_wrap();
    bit ok;
    lat = 0; i_arready = 1'b1; i_ready = 1'b0; fault_addr = 32'hFFFF_FFFC;
    do_reset();
    wait_valid(10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fw_timeout got no o_valid want o_valid within 10 cycles"); end
    i_redirect = 1'b1; i_redirect_pc = 32'hFFFF_FFFE;
    @(negedge i_clk);
    i_redirect = 1'b0;
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL fw_align got av=%b a=%h want 1 fffffffc", o_arvalid, o_araddr); end
    wait_valid(10, ok);
    checks++; if (!ok || o_pc !== 32'hFFFF_FFFC || o_ins_err !== 1'b1 || o_instr !== 32'h0000_0013)
      begin errors++; $display("FAIL fw_fault got ok=%b pc=%h e=%b i=%h want 1 fffffffc 1 00000013", ok, o_pc, o_ins_err, o_instr); end
    i_ready = 1'b1;
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b1 || o_araddr !== 32'h0000_0000) begin errors++; $display("FAIL fw_wrap got av=%b a=%h want 1 00000000", o_arvalid, o_araddr); end
    wait_valid(10, ok);
    checks++; if (!ok || o_pc !== 32'h0 || o_ins_err !== 1'b0 || o_instr !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL fw_after got ok=%b pc=%h e=%b i=%h want 1 00000000 0 ffffffff", ok, o_pc, o_ins_err, o_instr); end
    fault_addr = 32'h0000_0001;
  endtask

  task automatic test_reset_mid();
    bit ok;
    lat = 3; i_arready = 1'b1; i_ready = 1'b1;
    do_reset();
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checks++; if (o_arvalid !== 1'b0 || o_rready !== 1'b0 || o_valid !== 1'b0)
      begin errors++; $display("FAIL mid_rst got av=%b rr=%b v=%b want 0 0 0", o_arvalid, o_rready, o_valid); end
    i_rst = 1'b0;
    wait_valid(15, ok);
    checks++; if (!ok || o_pc !== 32'h8000_0000 || o_instr !== 32'h7FFF_FFFF)
      begin errors++; $display("FAIL mid_restart got ok=%b pc=%h i=%h want 1 80000000 7fffffff", ok, o_pc, o_instr); end
    lat = 0;
  endtask

  initial begin
    test_reset();
    test_stall();
    test_redirect_wait();
    test_redirect_req();
    test_redirect_ready();
    test_fault_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
